ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It is the opposite direction of the keyboard receive path. It sends single command bytes to the keyboard, such as 0xED set-LEDs, its LED mask, and 0xFF reset. It drives the shared key_clk/key_data lines through open-drain enables, and it sits beside the receiver under top, fed by game_control. It generates the request-to-send inhibit itself, then shifts the frame out on device-generated clock edges and checks the device's ACK.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_sync_edge.sv | 29 ++
 rtl/ps2_host_tx.sv | 134 +++++++++++++
 tb/tb_ps2_host_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmit and device receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } ps2_tx_state_e;

    localparam int   PS2_FRAME_BITS = 11;
    localparam logic PS2_ACK_LEVEL  = 1'b0;

    function automatic int us_to_cycles(input int clk_hz, input int us);
        return clk_hz / 1_000_000 * us;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pin plus falling-edge detect on the
// synchronized level.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fe
);

    logic s1, s2, s2_q;

    // Reset to 1 so an idle (released) bus never produces a spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1   <= pin;
            s2   <= s1;
            s2_q <= s2;
        end
    end

    assign level = s2;
    assign fe    = s2_q & ~s2;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: request-to-send inhibit, frame shift
// on device clock falling edges, ACK check and timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int INHIBIT_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int TIMEOUT_CYC = us_to_cycles(CLK_HZ, TIMEOUT_US);
    localparam int INH_W       = $clog2(INHIBIT_CYC + 1);
    localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);

    ps2_tx_state_e state;

    logic                      clk_lvl, clk_fe;
    logic                      data_lvl, data_fe_unused;
    // Start bit is driven directly in START, so only data, parity and stop shift.
    logic [PS2_FRAME_BITS-2:0] shreg;
    logic [3:0]                edge_cnt;
    logic [INH_W-1:0]          inh_cnt;
    logic [TO_W-1:0]           to_cnt;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_clk_in),
        .level (clk_lvl),
        .fe    (clk_fe)
    );

    ps2_sync_edge u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_data_in),
        .level (data_lvl),
        .fe    (data_fe_unused)
    );

    assign tx_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            shreg       <= '0;
            edge_cnt    <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        shreg       <= {1'b1, ~^tx_data, tx_data};
                        edge_cnt    <= '0;
                        inh_cnt     <= '0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        state       <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt == INH_W'(INHIBIT_CYC - 1)) begin
                        ps2_data_oe <= 1'b1;
                        state       <= S_START;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                S_START: begin
                    ps2_clk_oe <= 1'b0;
                    to_cnt     <= '0;
                    state      <= S_SHIFT;
                end
                S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                    if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        err         <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (state == S_SHIFT) begin
                            if (clk_fe) begin
                                ps2_data_oe <= ~shreg[0];
                                shreg       <= {1'b0, shreg[PS2_FRAME_BITS-2:1]};
                                edge_cnt    <= edge_cnt + 1'b1;
                                // Stop bit goes out on the 10th edge.
                                if (edge_cnt == 4'(PS2_FRAME_BITS - 2))
                                    state <= S_ACK;
                            end
                        end else if (state == S_ACK) begin
                            if (clk_fe) begin
                                ps2_data_oe <= 1'b0;
                                if (data_lvl == PS2_ACK_LEVEL) begin
                                    state <= S_WAIT_IDLE;
                                end else begin
                                    err   <= 1'b1;
                                    state <= S_IDLE;
                                end
                            end
                        end else if (clk_lvl && data_lvl) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a 40-cycle PS/2
// device model; expected frame bits are queued at send time.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int acc_cnt = 0;
    logic exp_q[$];

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_HZ     (1_000_000),
        .INHIBIT_US (100),
        .TIMEOUT_US (2000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
        if (!rst && tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Request a byte, queue its expected frame, and measure the inhibit phase.
    task automatic send(input logic [7:0] b, input bit hold, input string tag);
        int   n;
        logic last;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(~^b);
        exp_q.push_back(1'b1);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
        check({tag, " clk_oe after accept"}, 32'(ps2_clk_oe), 32'd1);
        check({tag, " data_oe in inhibit"}, 32'(ps2_data_oe), 32'd0);
        n    = 0;
        last = 1'b0;
        while (ps2_clk_oe === 1'b1 && n < 400) begin
            last = ps2_data_oe;
            n++;
            @(negedge clk);
        end
        check({tag, " clk_oe length"}, 32'(n), 32'd101);
        check({tag, " data_oe in last inhibit cycle"}, 32'(last), 32'd1);
    endtask

    // Device: 20 cycles high, sample data, 20 cycles low; ACK pulls data on clock 11.
    task automatic device(input int nclk, input bit ack, input string tag);
        logic e;
        for (int k = 1; k <= nclk; k++) begin
            cycles(20);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("%s frame bit %0d", tag, k - 1), 32'(ps2_data_in), 32'(e));
            end
            if (k == 11 && ack) begin
                dev_data_low = 1'b1;
                cycles(2);
            end
            dev_clk_low = 1'b1;
            cycles(20);
            dev_clk_low = 1'b0;
        end
        cycles(2);
        dev_data_low = 1'b0;
    endtask

    task automatic good_frame(input logic [7:0] b, input string tag);
        int d0, e0, t;
        d0 = done_cnt;
        e0 = err_cnt;
        send(b, 1'b0, tag);
        device(11, 1'b1, tag);
        t = 0;
        while (done_cnt == d0 && t < 100) begin
            cycles(1);
            t++;
        end
        cycles(2);
        check({tag, " done pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, " err pulses"}, 32'(err_cnt - e0), 32'd0);
        check({tag, " tx_ready"}, 32'(tx_ready), 32'd1);
    endtask

    initial begin
        int d0, e0, a0, k;

        cycles(3);
        check("reset tx_ready", 32'(tx_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("reset data_oe", 32'(ps2_data_oe), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        rst = 1'b0;
        cycles(2);

        good_frame(8'hED, "send_ed");
        good_frame(8'h01, "send_01");
        good_frame(8'h00, "send_00");

        // Device leaves data high on the 11th clock.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hA5, 1'b0, "nack");
        device(11, 1'b0, "nack");
        cycles(5);
        check("nack err pulses", 32'(err_cnt - e0), 32'd1);
        check("nack done pulses", 32'(done_cnt - d0), 32'd0);
        check("nack clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("nack data_oe", 32'(ps2_data_oe), 32'd0);
        check("nack tx_ready", 32'(tx_ready), 32'd1);

        // Device never clocks after release.
        e0 = err_cnt;
        send(8'h3C, 1'b0, "timeout");
        k = 0;
        while (err !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("timeout latency", 32'(k), 32'd2000);
        check("timeout clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("timeout data_oe", 32'(ps2_data_oe), 32'd0);
        cycles(1);
        check("timeout err width", 32'(err), 32'd0);
        check("timeout err pulses", 32'(err_cnt - e0), 32'd1);

        // Reset after the 5th falling edge; d4 of 0x0F is 0 so data_oe is held.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h0F, 1'b0, "midrst");
        device(5, 1'b1, "midrst");
        check("midrst data_oe before", 32'(ps2_data_oe), 32'd1);
        rst = 1'b1;
        cycles(1);
        check("midrst clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("midrst data_oe", 32'(ps2_data_oe), 32'd0);
        check("midrst tx_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        cycles(3);
        check("midrst no done", 32'(done_cnt - d0), 32'd0);
        check("midrst no err", 32'(err_cnt - e0), 32'd0);
        good_frame(8'hFF, "send_ff");

        // tx_valid held across a full transfer.
        a0 = acc_cnt;
        send(8'hAB, 1'b1, "hold");
        device(11, 1'b1, "hold");
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("hold done seen", 32'(done), 32'd1);
        check("hold single accept", 32'(acc_cnt - a0), 32'd1);
        check("hold clk_oe at done", 32'(ps2_clk_oe), 32'd0);
        cycles(1);
        check("hold second frame start", 32'(ps2_clk_oe), 32'd1);
        tx_valid = 1'b0;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
